sdram_capture_writer: RTL and testbench

- Downstream consumer of the Nios-programmed 20-bit SDRAM address register.
- Takes `base_addr` from that register plus a sample count and a start strobe.
- Streams ADC samples into a small FIFO and writes them to SDRAM through an Avalon-MM write master at consecutive word addresses.
- Reports busy, done and overflow status back to the Nios PIO inputs.

---
 rtl/scope_pkg.sv | 14 +
 rtl/sample_fifo.sv | 71 +++++++
 rtl/sdram_capture_writer.sv | 127 ++++++++++++
 tb/tb_sdram_capture_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scope_pkg.sv
// Shared types and default sizes for the SDRAM capture path.
package scope_pkg;

  localparam int ADDR_W_DEF     = 20;
  localparam int DATA_W_DEF     = 16;
  localparam int FIFO_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_e;

endpackage

// File: rtl/sample_fifo.sv
// Synchronous sample FIFO with a registered head word. A pushed sample
// becomes visible on dout/empty one cycle after the push, never the same cycle.
module sample_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              push_ok, pop_ok;

  assign full  = (count_q == DEPTH_CNT);
  assign empty = (count_q == '0);
  assign dout  = head_q;

  // Next pointers, occupancy and head word; a push at full is refused even with a pop.
  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + (PTR_W+1)'(1);
    else if (pop_ok && !push_ok) count_d = count_q - (PTR_W+1)'(1);
    if (pop_ok) begin
      if (count_q > (PTR_W+1)'(1)) head_d = mem[rd_ptr_q + PTR_W'(1)];
      else if (push_ok)            head_d = din;
    end else if (empty && push_ok) begin
      head_d = din;
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= din;
  end

  // Pointer, count and head registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

endmodule

// File: rtl/sdram_capture_writer.sv
// Captures a fixed number of ADC samples and writes them to consecutive
// SDRAM word addresses through an Avalon-MM write master.
module sdram_capture_writer
  import scope_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] capture_len,
  input  logic              start,
  input  logic              abort,
  input  logic              adc_valid,
  input  logic [DATA_W-1:0] adc_data,
  output logic              adc_ready,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] acc_q, acc_d;
  logic [ADDR_W-1:0] wr_q, wr_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_dout;
  logic              ready_c;

  sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (fifo_push),
    .pop     (fifo_pop),
    .din     (adc_data),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // The FIFO is only ever non-empty while busy, so its state alone drives the write master.
  assign adc_ready     = ready_c;
  assign avm_write     = !fifo_empty;
  assign avm_writedata = fifo_dout;
  assign avm_address   = base_q + wr_q;
  assign busy          = (state_q != IDLE);
  assign done          = done_q;
  assign overflow      = ovf_q;

  // Next-state logic: sample acceptance, write completion and status flags.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    acc_d     = acc_q;
    wr_d      = wr_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    ready_c   = (state_q == CAPTURE) && !fifo_full && (acc_q != len_q);
    fifo_push = adc_valid && ready_c && !abort;
    fifo_pop  = !fifo_empty && !avm_waitrequest;
    if (fifo_pop) wr_d = wr_q + ADDR_W'(1);
    case (state_q)
      IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (capture_len == '0) begin
            done_d = 1'b1;
          end else begin
            done_d  = 1'b0;
            base_d  = base_addr;
            len_d   = capture_len;
            acc_d   = '0;
            wr_d    = '0;
            state_d = CAPTURE;
          end
        end
      end
      CAPTURE: begin
        if (adc_valid && fifo_full) ovf_d = 1'b1;
        if (fifo_push) acc_d = acc_q + ADDR_W'(1);
        if (abort || (acc_d == len_q)) state_d = DRAIN;
      end
      DRAIN: begin
        if (fifo_empty) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state, latched capture parameters, counters and sticky flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
      wr_q    <= wr_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_sdram_capture_writer.sv
// Randomised scoreboard bench for sdram_capture_writer.
module tb_sdram_capture_writer;

  localparam int AW    = 20;
  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] capture_len;
  logic          start, abort, adc_valid, avm_waitrequest;
  logic [DW-1:0] adc_data;
  logic          adc_ready, avm_write, busy, done, overflow;
  logic [AW-1:0] avm_address;
  logic [DW-1:0] avm_writedata;

  sdram_capture_writer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .base_addr       (base_addr),
    .capture_len     (capture_len),
    .start           (start),
    .abort           (abort),
    .adc_valid       (adc_valid),
    .adc_data        (adc_data),
    .adc_ready       (adc_ready),
    .avm_address     (avm_address),
    .avm_write       (avm_write),
    .avm_writedata   (avm_writedata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           exp_q[$];
  logic [DW-1:0] mq[$];
  int            mstate;
  logic [AW-1:0] mbase, mlen, macc;
  logic          mdone, movf;
  int            cur_state, cur_occ;
  logic          cur_done, cur_ovf;
  int            n_chk = 0;
  int            n_fail = 0;
  int            nwr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    mstate = 0; mbase = '0; mlen = '0; macc = '0; mdone = 1'b0; movf = 1'b0;
    cur_state = 0; cur_occ = 0; cur_done = 1'b0; cur_ovf = 1'b0;
  endtask

  // Reference: a queue of stored samples; model state moves one clock edge per call.
  task automatic model_step();
    int pre;
    logic [AW-1:0] addr;
    if (!reset_n) begin
      model_clear();
      return;
    end
    pre = mq.size();
    cur_state = mstate; cur_occ = pre; cur_done = mdone; cur_ovf = movf;
    if (pre > 0 && !avm_waitrequest) void'(mq.pop_front());
    case (mstate)
      0: if (start) begin
        movf = 1'b0;
        if (capture_len == '0) mdone = 1'b1;
        else begin
          mdone = 1'b0; mstate = 1; mbase = base_addr; mlen = capture_len; macc = '0;
        end
      end
      1: begin
        if (adc_valid && pre == DEPTH) movf = 1'b1;
        if (adc_valid && !abort && pre < DEPTH) begin
          addr = mbase + macc;
          mq.push_back(adc_data);
          exp_q.push_back('{a: addr, d: adc_data});
          macc = macc + 1'b1;
        end
        if (abort || macc == mlen) mstate = 2;
      end
      default: if (pre == 0) begin mstate = 0; mdone = 1'b1; end
    endcase
  endtask

  task automatic cyc(input logic st, input logic ab, input logic v,
                     input logic [DW-1:0] d, input logic wq);
    @(negedge clk);
    start = st; abort = ab; adc_valid = v; adc_data = d; avm_waitrequest = wq;
    model_step();
  endtask

  task automatic wait_idle();
    int i = 0;
    while (!(mstate == 0 && mq.size() == 0) && i < 400) begin
      cyc(1'b0, 1'b0, 1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 2) == 0));
      i++;
    end
    chk("drain_bounded", mstate, 0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_avm_write"}, avm_write, 0);
    chk({tag, "_avm_address"}, avm_address, 0);
    chk({tag, "_avm_writedata"}, avm_writedata, 0);
    chk({tag, "_adc_ready"}, adc_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_overflow"}, overflow, 0);
  endtask

  // Monitor: just before each rising edge, compare status and writes with the model.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      chk("busy", busy, (cur_state != 0));
      chk("done", done, cur_done);
      chk("overflow", overflow, cur_ovf);
      chk("adc_ready", adc_ready, (cur_state == 1 && cur_occ < DEPTH));
      chk("avm_write", avm_write, (cur_occ != 0));
      if (avm_write) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected no write", avm_address, avm_writedata);
        end else begin
          chk("avm_address", avm_address, exp_q[0].a);
          chk("avm_writedata", avm_writedata, exp_q[0].d);
          if (!avm_waitrequest) begin
            void'(exp_q.pop_front());
            nwr++;
          end
        end
      end
    end
  end

  initial begin
    int w0;
    start = 0; abort = 0; adc_valid = 0; adc_data = '0; avm_waitrequest = 0;
    base_addr = '0; capture_len = '0;
    model_clear();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    reset_n = 1'b1;
    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);

    // Basic capture of 0xA1..0xA4 at 0x00100.
    base_addr = 20'h00100; capture_len = 20'd4; w0 = nwr;
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, DW'(16'hA1 + i), 1'b0);
    wait_idle();
    chk("t1_writes", nwr - w0, 4);
    chk("t1_done", done, 1);
    chk("t1_busy", busy, 0);
    chk("t1_overflow", overflow, 0);

    // Address wrap past the top of the word space.
    base_addr = 20'hFFFFE; capture_len = 20'd4; w0 = nwr;
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b0);
    wait_idle();
    chk("t2_writes", nwr - w0, 4);

    // Long stall with a free-running ADC: FIFO fills and samples are dropped.
    base_addr = 20'h0ABC0; capture_len = 20'd16; w0 = nwr;
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    wait_idle();
    chk("t3_writes", nwr - w0, 8);
    chk("t3_overflow", overflow, 1);
    chk("t3_done", done, 1);

    // Abort after three samples; the abort-cycle sample is not stored.
    base_addr = 20'h00200; capture_len = 20'd10; w0 = nwr;
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, DW'($urandom), 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 16'hBEEF, 1'b0);
    wait_idle();
    chk("t4_writes", nwr - w0, 3);
    chk("t4_done", done, 1);

    // Zero-length start, then a start while busy that must be ignored.
    capture_len = '0; w0 = nwr;
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    chk("t5_len0_done", done, 1);
    chk("t5_len0_writes", nwr - w0, 0);
    base_addr = 20'h30000; capture_len = 20'd8;
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b1, DW'($urandom), 1'($urandom_range(0, 1)));
    base_addr = 20'h55555; capture_len = 20'd3;
    cyc(1'b1, 1'b0, 1'b1, DW'($urandom), 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, DW'($urandom), 1'($urandom_range(0, 1)));
    wait_idle();
    chk("t5_writes", nwr - w0, 8);

    // Reset in the middle of a stalled write.
    base_addr = 20'h12345; capture_len = 20'd8;
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, DW'($urandom), 1'b1);
    @(negedge clk);
    chk("t6_write_before_reset", avm_write, 1);
    reset_n = 1'b0;
    start = 0; abort = 0; adc_valid = 0; avm_waitrequest = 0;
    model_clear();
    #1 check_all_zero("t6_midreset");
    repeat (2) cyc(1'b0, 1'b0, 1'b0, '0, 1'b0);
    reset_n = 1'b1;
    base_addr = 20'h40000; capture_len = 20'd5; w0 = nwr;
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, DW'($urandom), 1'($urandom_range(0, 1)));
    wait_idle();
    chk("t6_writes", nwr - w0, 5);

    // Random captures with gaps, stalls and occasional aborts.
    for (int t = 0; t < 10; t++) begin
      base_addr = AW'($urandom); capture_len = AW'($urandom_range(1, 20));
      cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
      for (int k = 0; k < 300 && mstate == 1; k++)
        cyc(1'b0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
            DW'($urandom), ($urandom_range(0, 2) == 0));
      wait_idle();
      chk("rand_done", done, 1);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
